// File: rtl/div_pkg.sv
// div_pkg: shared FSM state encoding and default operand width for the radix-4 divider.
// Contents: DIV_WIDTH (default WIDTH), div_state_e (IDLE, CALC, FIX, DONE).
package div_pkg;
    localparam int DIV_WIDTH = 32;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;
endpackage

// File: rtl/div_radix4_step.sv
// div_radix4_step: one combinational radix-4 restoring step on magnitudes.
// Ports: rem_i partial remainder (< d_i), bits_i next two dividend bits, d_i divisor magnitude,
//        digit_o retired quotient digit (0..3), rem_o next partial remainder.
module div_radix4_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [1:0]       bits_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [1:0]       digit_o,
    output logic [WIDTH-1:0] rem_o
);
    // Three guard bits: the shifted remainder and 3*d both stay below 2^(WIDTH+2),
    // so the top bit of each difference is a reliable sign.
    logic [WIDTH+2:0] p, d1, d2, d3, t1, t2, t3;
    assign p  = {1'b0, rem_i, bits_i};
    assign d1 = {3'b000, d_i};
    assign d2 = {2'b00, d_i, 1'b0};
    assign d3 = d1 + d2;
    assign t1 = p - d1;
    assign t2 = p - d2;
    assign t3 = p - d3;
    assign digit_o = !t3[WIDTH+2] ? 2'd3 : !t2[WIDTH+2] ? 2'd2 : !t1[WIDTH+2] ? 2'd1 : 2'd0;
    assign rem_o   = WIDTH'(!t3[WIDTH+2] ? t3 : !t2[WIDTH+2] ? t2 : !t1[WIDTH+2] ? t1 : p);
endmodule

// File: rtl/div_radix4.sv
// div_radix4: iterative radix-4 signed/unsigned divider with request/response handshake.
// Ports: clk, reset_n (async active-low); req_valid/req_ready accept x, y, x_signed, y_signed;
//        kill aborts an operation in flight; resp_valid/resp_ready deliver quotient q, remainder r.
// Option: define DIV_EARLY_OUT_EN to skip iteration when y==0 or |x|<|y|.
module div_radix4 import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             x_signed,
    input  logic             y_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             kill,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);
    localparam int CW = $clog2(WIDTH);
    div_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d, d_q, d_d, quo_q, quo_d, rem_q, rem_d, q_q, q_d, r_q, r_d;
    logic xneg_q, xneg_d, qneg_q, qneg_d, yzero_q, yzero_d;
    logic x_neg, y_neg, early;
    logic [WIDTH-1:0] x_mag, y_mag, rem_nx, q_fix, r_fix;
    logic [1:0] digit;
    assign x_neg = x_signed & x[WIDTH-1];
    assign y_neg = y_signed & y[WIDTH-1];
    assign x_mag = x_neg ? -x : x;
    assign y_mag = y_neg ? -y : y;
`ifdef DIV_EARLY_OUT_EN
    assign early = (y == '0) || (x_mag < y_mag);
`else
    assign early = 1'b0;
`endif
    // quo_q doubles as dividend shift register: its top two bits feed the step,
    // retired digits shift in at the bottom.
    div_radix4_step #(.WIDTH(WIDTH)) u_step (
        .rem_i   (rem_q),
        .bits_i  (quo_q[WIDTH-1:WIDTH-2]),
        .d_i     (d_q),
        .digit_o (digit),
        .rem_o   (rem_nx)
    );
    // Most-negative / -1 needs no special case: its magnitude quotient already equals x.
    assign q_fix = yzero_q ? '1 : qneg_q ? -quo_q : quo_q;
    assign r_fix = yzero_q ? x_q : xneg_q ? -rem_q : rem_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        d_d     = d_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        xneg_d  = xneg_q;
        qneg_d  = qneg_q;
        yzero_d = yzero_q;
        q_d     = q_q;
        r_d     = r_q;
        unique case (state_q)
            IDLE: if (req_valid) begin
                state_d = early ? FIX : CALC;
                cnt_d   = '0;
                x_d     = x;
                d_d     = y_mag;
                quo_d   = early ? '0 : x_mag;
                rem_d   = early ? x_mag : '0;
                xneg_d  = x_neg;
                qneg_d  = x_neg ^ y_neg;
                yzero_d = y == '0;
            end
            CALC: begin
                quo_d   = {quo_q[WIDTH-3:0], digit};
                rem_d   = rem_nx;
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CW'(WIDTH/2-1) ? FIX : CALC;
            end
            FIX: begin
                state_d = DONE;
                q_d     = q_fix;
                r_d     = r_fix;
            end
            DONE: state_d = resp_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (kill && state_q != IDLE) begin
            state_d = IDLE;
            q_d     = q_q;
            r_d     = r_q;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            d_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            xneg_q  <= 1'b0;
            qneg_q  <= 1'b0;
            yzero_q <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            d_q     <= d_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            xneg_q  <= xneg_d;
            qneg_q  <= qneg_d;
            yzero_q <= yzero_d;
            q_q     <= q_d;
            r_q     <= r_d;
        end
    end
    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == DONE;
    assign q = q_q;
    assign r = r_q;
endmodule

// File: doc/div_radix4.md
DIV_RADIX4 -- requirements
Module: div_radix4

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; even, >= 4.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  block can accept a request.
REQ-006 SHALL have port x_signed  input  1  dividend is two's complement.
REQ-007 SHALL have port y_signed  input  1  divisor is two's complement.
REQ-008 SHALL have port x  input  WIDTH  dividend.
REQ-009 SHALL have port y  input  WIDTH  divisor.
REQ-010 SHALL have port kill  input  1  abort the operation in flight.
REQ-011 SHALL have port resp_valid  output  1  result available.
REQ-012 SHALL have port resp_ready  input  1  consumer takes the result.
REQ-013 SHALL have port q  output  WIDTH  quotient.
REQ-014 SHALL have port r  output  WIDTH  remainder.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-016 SHALL drive req_ready=1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge with req_valid&req_ready, capture x, y, x_signed and y_signed, and enter CALC; input changes after acceptance SHALL be ignored.
REQ-018 SHALL in CALC retire 2 quotient bits per cycle (radix-4, three trial subtractions of 1y, 2y, 3y on magnitudes) for exactly WIDTH/2 cycles, then enter FIX.
REQ-019 SHALL in FIX apply sign correction for one cycle: q negated if operand signs differ; r takes the dividend's sign (truncating division, |r|<|y|), then enter DONE.
REQ-020 SHALL hold resp_valid=1 and stable q and r in DONE until a rising edge with resp_ready=1, then return to IDLE.
REQ-021 SHALL, without DIV_EARLY_OUT_EN, assert resp_valid exactly WIDTH/2+2 edges after the accept edge (18 for WIDTH=32).
REQ-022 SHALL, when y==0, return q=all-ones and r=x with normal latency.
REQ-023 SHALL, for a signed overflow (x=most negative value, y=-1, both signed), return q=x and r=0.
REQ-024 SHALL, when kill=1 on a rising edge in CALC, FIX or DONE, return to IDLE with resp_valid=0; kill SHALL have no effect in IDLE.
REQ-025 SHALL give kill priority over resp_ready when both are asserted in DONE.
REQ-026 SHALL keep q and r unchanged outside DONE; their values there SHALL not be relied on.

Reset
REQ-027 SHALL, while reset_n=0, force IDLE, req_ready=1, resp_valid=0, q=0, r=0 and the iteration counter to 0, independent of clk.
REQ-028 SHALL, if reset is asserted mid-operation, discard the operation; after release the block SHALL behave as freshly reset.

Configuration
REQ-029 SHALL, with macro DIV_EARLY_OUT_EN defined, skip CALC when y==0 or |x|<|y|: the block SHALL go from accept directly to FIX, and resp_valid SHALL rise 2 edges after accept with the results of REQ-019 and REQ-022.
REQ-030 SHALL, without DIV_EARLY_OUT_EN, always take the full latency of REQ-021 and contain no magnitude-compare logic.

Structure
REQ-031 SHALL place the FSM state encoding and the default WIDTH constant in the shared package div_pkg.
REQ-032 SHALL implement one radix-4 step (partial remainder in, three trial differences, 2-bit digit and next partial remainder out) as the combinational sub-module div_radix4_step.

Verification
REQ-033 SHALL cover unsigned 100/7, WIDTH=32 -> q=14, r=2, resp_valid 18 edges after accept.
REQ-034 SHALL cover signed -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; and unsigned 0xFFFFFFF9/2 -> q=0x7FFFFFFC, r=1.
REQ-035 SHALL cover x=5, y=0 -> q=0xFFFFFFFF, r=5; and signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
REQ-036 SHALL cover resp_ready held low for 5 cycles in DONE -> q, r and resp_valid stable, then IDLE one edge after resp_ready=1.
REQ-037 SHALL cover kill at CALC cycle 4 and, separately, reset_n low at CALC cycle 7 -> IDLE, resp_valid=0, req_ready=1; the next request 100/7 SHALL return 14 r 2.
REQ-038 SHALL cover, with DIV_EARLY_OUT_EN, unsigned 3/10 -> q=0, r=3, resp_valid 2 edges after accept; without the macro the same request SHALL give the same result after 18 edges.
